// File: rtl/or1200_ack_gate_mc.sv
// Per-channel ack holding gate: holds cache acks while unstall is low, then releases one per cycle.
// Optional sticky overflow flag enabled by defining OR1200_ACK_GATE_OVF_EN.
module or1200_ack_gate_mc #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] ack_i,
  input  logic [NCH-1:0] unstall_i,
  input  logic           flush_i,
  output logic [NCH-1:0] ack_o,
  output logic [NCH-1:0] stall_o,
  output logic [NCH-1:0] ovf_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  for (genvar g = 0; g < int'(NCH); g++) begin : g_ch
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_rel;
    logic          ack_q, ack_d;
    logic          stall_q, stall_d;
    logic          full;
    logic          inc;

    // Full is judged on the pre-release count, so an ack at DEPTH is dropped even when releasing.
    always_comb begin
      full    = (cnt_q == CNT_MAX);
      inc     = ack_i[g] & ~full;
      cnt_rel = cnt_q - CNT_ONE + CW'(inc);
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      stall_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ack_i[g]) begin
            if (unstall_i[g]) begin
              ack_d = 1'b1;
            end else begin
              cnt_d   = CNT_ONE;
              stall_d = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT, ST_DRAIN: begin
          if (unstall_i[g]) begin
            ack_d   = 1'b1;
            cnt_d   = cnt_rel;
            state_d = (cnt_rel == '0) ? ST_IDLE : ST_DRAIN;
          end else begin
            stall_d = 1'b1;
            cnt_d   = cnt_q + CW'(inc);
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (flush_i) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ack_d   = 1'b0;
        stall_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        ack_q   <= 1'b0;
        stall_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ack_q   <= ack_d;
        stall_q <= stall_d;
      end
    end

    assign ack_o[g]   = ack_q;
    assign stall_o[g] = stall_q;

`ifdef OR1200_ACK_GATE_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky until flush or reset.
    always_comb begin
      ovf_d = ovf_q | (ack_i[g] & full);
      if (flush_i) begin
        ovf_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_d;
      end
    end

    assign ovf_o[g] = ovf_q;
`else
    assign ovf_o[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_or1200_ack_gate_mc.sv
// Scoreboard bench for or1200_ack_gate_mc: a held-ack count model predicts each cycle's outputs.
module tb_or1200_ack_gate_mc;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DEPTH = 3;

  typedef struct packed {
    logic [NCH-1:0] ack;
    logic [NCH-1:0] stall;
    logic [NCH-1:0] ovf;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] ack_i;
  logic [NCH-1:0] unstall_i;
  logic           flush_i;
  logic [NCH-1:0] ack_o;
  logic [NCH-1:0] stall_o;
  logic [NCH-1:0] ovf_o;

  or1200_ack_gate_mc #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ack_i     (ack_i),
    .unstall_i (unstall_i),
    .flush_i   (flush_i),
    .ack_o     (ack_o),
    .stall_o   (stall_o),
    .ovf_o     (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t           exp_q[$];
  int             held[NCH];
  logic [NCH-1:0] ovf_m;
  int             n_cmp;
  int             n_fail;
  int             n_ack_pulses;

  task automatic check(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) held[c] = 0;
    ovf_m = '0;
  endtask

  // Drive one cycle of inputs and queue the outputs the model predicts after the next edge.
  task automatic step(input logic [NCH-1:0] a, input logic [NCH-1:0] u, input logic f);
    exp_t e;
    int   avail;
    bit   acc, drop;
    @(negedge clk);
    rst       = 1'b1;
    ack_i     = a;
    unstall_i = u;
    flush_i   = f;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      if (f) begin
        held[c]  = 0;
        ovf_m[c] = 1'b0;
      end else begin
        acc   = a[c] && (held[c] < DEPTH);
        drop  = a[c] && (held[c] == DEPTH);
        avail = held[c] + (acc ? 1 : 0);
        if (u[c] && avail > 0) begin
          e.ack[c] = 1'b1;
          held[c]  = avail - 1;
        end else begin
          held[c]    = avail;
          e.stall[c] = (avail > 0);
        end
`ifdef OR1200_ACK_GATE_OVF_EN
        if (drop) ovf_m[c] = 1'b1;
`else
        if (drop) ovf_m[c] = 1'b0;
`endif
      end
    end
    e.ovf = ovf_m;
    exp_q.push_back(e);
  endtask

  // Pull reset low between edges; outputs must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst       = 1'b0;
    ack_i     = '0;
    unstall_i = '0;
    flush_i   = 1'b0;
    #1;
    check("async_rst_ack", ack_o, '0);
    check("async_rst_stall", stall_o, '0);
    check("async_rst_ovf", ovf_o, '0);
    model_reset();
    exp_q.push_back('0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ack_o", ack_o, e.ack);
      check("stall_o", stall_o, e.stall);
      check("ovf_o", ovf_o, e.ovf);
      for (int c = 0; c < NCH; c++) if (e.ack[c]) n_ack_pulses++;
    end
  end

  initial begin
    logic [NCH-1:0] a, u;
    n_cmp = 0;
    n_fail = 0;
    n_ack_pulses = 0;
    rst = 1'b0;
    ack_i = '0;
    unstall_i = '0;
    flush_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", ack_o, '0);
    check("reset_stall", stall_o, '0);
    check("reset_ovf", ovf_o, '0);

    // Bypass on ch0
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Hold two acks on ch1, release after a wait
    step(4'b0010, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    repeat (6) step(4'b0000, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0010, 1'b0);

    // Interrupted drain on ch2
    repeat (3) step(4'b0100, 4'b0000, 1'b0);
    step(4'b0000, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b0100, 1'b0);

    // Overflow on ch3, including an ack at full during release
    repeat (4) step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    repeat (4) step(4'b0000, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // All channels concurrently
    repeat (2) step(4'b1111, 4'b0000, 1'b0);
    repeat (3) step(4'b0000, 4'b1111, 1'b0);

    // Flush mid-WAIT with two held, acks in flush cycle discarded
    repeat (2) step(4'b0101, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    repeat (3) step(4'b0000, 4'b1111, 1'b0);

    // Reset mid-DRAIN on ch1
    repeat (3) step(4'b0010, 4'b0000, 1'b0);
    step(4'b0000, 4'b0010, 1'b0);
    async_reset();
    repeat (3) step(4'b0000, 4'b1111, 1'b0);

    // Randomized phases with varying unstall density
    for (int i = 0; i < 3000; i++) begin
      a = NCH'($urandom);
      case ((i / 200) % 3)
        0:       u = NCH'($urandom) & NCH'($urandom);
        1:       u = NCH'($urandom);
        default: u = NCH'($urandom) | NCH'($urandom);
      endcase
      if ($urandom_range(0, 399) == 0) async_reset();
      else step(a, u, ($urandom_range(0, 63) == 0));
    end
    repeat (4) step('0, '1, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d entries left, expected 0", exp_q.size());
    end
    n_cmp++;
    if (n_ack_pulses == 0) begin
      n_fail++;
      $display("FAIL ack_activity: got %0d expected release pulses, expected nonzero", n_ack_pulses);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/or1200_ack_gate_mc.md
# or1200_ack_gate_mc

Multi-channel, parametrised successor to the single-channel ack-delay FSM. It sits between the cache memory ack sources and the CPU-side ack consumers. Per channel, it holds one or more cache acks while the encryption FSM has not asserted unstall, and drives a stall indication during that time. Once unstall arrives, it releases the held acks one per cycle.

## Interface
- NCH, 4: number of independent ack channels (≥1).
- DEPTH, 3: maximum held acks per channel (≥1); counter width CW = $clog2(DEPTH+1), local.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; rst==0 forces reset state immediately.
- ack_i  in  NCH  per-channel ack pulse from cache memory (one ack per high cycle).
- unstall_i  in  NCH  per-channel unstall from encryption FSM, level-sensitive.
- flush_i  in  1  synchronous global clear, highest priority.
- ack_o  out  NCH  registered released-ack pulse, one cycle per ack.
- stall_o  out  NCH  registered; high while channel holds acks and unstall is low.
- ovf_o  out  NCH  sticky overflow flag (see Configuration).

## Operation
- Each channel is independent: a 3-state FSM (IDLE, WAIT, DRAIN) plus a counter cnt[CW-1:0] in 0..DEPTH.
- inc = ack_i & (cnt < DEPTH). An ack arriving with cnt==DEPTH is dropped and flags overflow.
- IDLE (cnt==0):
  - ack_i & unstall_i → ack_o<=1 (bypass), stay IDLE, cnt stays 0.
  - ack_i & !unstall_i → cnt<=1, stall_o<=1, go to WAIT.
  - Otherwise ack_o<=0, stall_o<=0.
- WAIT (cnt>0, stalled):
  - !unstall_i → stall_o<=1, cnt<=cnt+inc, ack_o<=0.
  - unstall_i → release: ack_o<=1, stall_o<=0, cnt<=cnt-1+inc. Next state is IDLE if the result is 0, else DRAIN.
- DRAIN (cnt>0, unstalled):
  - unstall_i → release exactly as in WAIT.
  - !unstall_i → no release, ack_o<=0, stall_o<=1, cnt<=cnt+inc, go to WAIT.
- flush_i → all channels: cnt<=0, state IDLE, ack_o<=0, stall_o<=0, ovf_o<=0. Any acks arriving in the flush cycle are discarded.
- Arithmetic: cnt-1+inc never underflows (release only when cnt>0) and never exceeds DEPTH (inc gated).

## Timing
- Reset values: ack_o=0, stall_o=0, ovf_o=0, cnt=0, state IDLE on all channels.
- Bypass latency: ack_i in cycle N with unstall_i high in IDLE → ack_o high in cycle N+1.
- Stall latency: first held ack in cycle N → stall_o high from cycle N+1.
- Release rate: at most one ack_o pulse per channel per cycle. A burst of k held acks drains in k consecutive unstalled cycles.
- Simultaneous ack_i and release in WAIT/DRAIN: net cnt unchanged, ack_o=1, state stays DRAIN.
- Simultaneous ack_i, cnt==DEPTH, and release: inc=0, so cnt ends at DEPTH-1 and overflow is flagged. Full is evaluated on the pre-release count.
- unstall_i dropping mid-drain stops release in that same cycle and re-raises stall_o next cycle.
- Asynchronous reset mid-operation discards all held acks. Outputs return to reset values without waiting for a clock edge.

## Configuration
- OR1200_ACK_GATE_OVF_EN defined: ovf_o[c] is set on the cycle after a dropped ack. It holds until flush_i or reset.
- Undefined: ovf_o is tied to 0 and overflow logic is removed. Acks at full are still dropped silently; all other behaviour is identical.

## Test plan
- Bypass: ch0 ack_i=1 with unstall_i=1 at cycle 5 → ack_o[0]=1 at cycle 6 only, stall_o[0] stays 0, cnt stays 0.
- Hold/release: ch1 acks at cycles 2,3 with unstall low, unstall high from cycle 10 → stall_o[1]=1 over cycles 3–10; ack_o[1]=1 in cycles 11 and 12; IDLE at 12.
- Interrupted drain (DEPTH=3): ch2 holds 3 acks; unstall high in cycle 20, low in 21, high in 22–23 → ack_o pulses at cycles 21, 23, 24; stall_o re-asserted at cycle 22.
- Overflow (macro defined, DEPTH=3): 4 acks to ch3 with unstall low → cnt=3, ovf_o[3]=1 after the 4th ack. After unstall, exactly 3 ack_o pulses occur and ovf_o stays 1 until flush_i.
- Concurrent channels: all 4 channels hold 2 acks and unstall together → each channel gives 2 ack_o pulses in the same 2 cycles, with no cross-channel interaction.
- Flush and reset: flush_i mid-WAIT with cnt=2 → next cycle all outputs 0, no later ack_o. rst low mid-DRAIN → outputs 0 immediately, asynchronously.
